fitness_eval: RTL and testbench

FITNESS_EVAL -- requirements
Module: fitness_eval

---
 rtl/genetico_pkg.sv | 25 ++
 rtl/fitness_eval_bit_match_cnt.sv | 26 ++
 rtl/fitness_eval.sv | 129 ++++++++++++
 tb/tb_fitness_eval.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/genetico_pkg.sv
//------------------------------------------------------------------------------
// Module : genetico_pkg
// Brief  : Shared sizing constants and FSM state type for the fitness evaluator.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package genetico_pkg;

  localparam int IN    = 3;
  localparam int OUT   = 2;
  localparam int ROW   = 2;
  localparam int COL   = 3;
  localparam int NVEC  = 2**IN;
  localparam int FIT_W = $clog2(NVEC*OUT+1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    FINISH = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fitness_eval_bit_match_cnt.sv
//------------------------------------------------------------------------------
// Module : bit_match_cnt
// Brief  : Combinational count of equal bit positions between two W-bit words.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module bit_match_cnt #(
  parameter  int W  = 2,
  localparam int CW = $clog2(W+1)
) (
  input  logic [W-1:0]  a_i,
  input  logic [W-1:0]  b_i,
  output logic [CW-1:0] cnt_o
);

  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < W; i++) begin
      cnt_o = cnt_o + CW'(~(a_i[i] ^ b_i[i]));
    end
  end

endmodule

`default_nettype wire

// File: rtl/fitness_eval.sv
//------------------------------------------------------------------------------
// Module : fitness_eval
// Brief  : Sweeps every input vector of a genetic circuit, holds each for SETTLE
//          cycles and accumulates matching output bits against a target table.
//          Optional macro FITNESS_ERRMAP_EN adds the per-vector mismatch map.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fitness_eval #(
  parameter  int IN     = genetico_pkg::IN,
  parameter  int OUT    = genetico_pkg::OUT,
  parameter  int SETTLE = 1,
  localparam int NV     = 2**IN,
  localparam int FIT_W  = $clog2(NV*OUT+1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [NV-1:0][OUT-1:0] target,
  input  logic [OUT-1:0]         circ_out,
  output logic [IN-1:0]          circ_inp,
  output logic                   busy,
  output logic                   done,
  output logic [FIT_W-1:0]       fitness,
  output logic                   perfect,
  output logic [NV-1:0]          err_map
);

  import genetico_pkg::*;

  localparam int               SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int               MW          = $clog2(OUT+1);
  localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE-1);
  localparam logic [IN-1:0]    INP_LAST    = {IN{1'b1}};
  localparam logic [FIT_W-1:0] FIT_MAX     = FIT_W'(NV*OUT);

  state_t           state_q, state_d;
  logic [IN-1:0]    inp_q, inp_d;
  logic [SW-1:0]    cnt_q, cnt_d;
  logic [FIT_W-1:0] fit_q, fit_d;
  logic [MW-1:0]    match;
  logic             sample;
  logic             clear;

  bit_match_cnt #(.W(OUT)) u_match (
    .a_i   (circ_out),
    .b_i   (target[inp_q]),
    .cnt_o (match)
  );

  // sample fires on the edge that closes the last settle cycle of a vector
  assign sample = (state_q == EVAL) && (cnt_q == SETTLE_LAST);
  assign clear  = (state_q == IDLE) && start;

  always_comb begin
    state_d = state_q;
    inp_d   = inp_q;
    cnt_d   = cnt_q;
    fit_d   = fit_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EVAL;
          inp_d   = '0;
          cnt_d   = '0;
          fit_d   = '0;
        end
      end
      EVAL: begin
        if (sample) begin
          fit_d = fit_q + FIT_W'(match);
          cnt_d = '0;
          if (inp_q == INP_LAST) begin
            state_d = FINISH;
            inp_d   = '0;
          end else begin
            inp_d = inp_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inp_q   <= '0;
      cnt_q   <= '0;
      fit_q   <= '0;
    end else begin
      state_q <= state_d;
      inp_q   <= inp_d;
      cnt_q   <= cnt_d;
      fit_q   <= fit_d;
    end
  end

`ifdef FITNESS_ERRMAP_EN
  logic [NV-1:0] err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= '0;
    end else if (clear) begin
      err_q <= '0;
    end else if (sample) begin
      err_q[inp_q] <= (circ_out != target[inp_q]);
    end
  end

  assign err_map = err_q;
`else
  assign err_map = '0;
`endif

  assign circ_inp = inp_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == FINISH);
  assign fitness  = fit_q;
  assign perfect  = (fit_q == FIT_MAX);

endmodule

`default_nettype wire

// File: tb/tb_fitness_eval.sv
//------------------------------------------------------------------------------
// Module : tb_fitness_eval
// Brief  : Self-checking bench for fitness_eval over three parameter sets.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fitness_eval;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, start;
  int               sel;
  logic [7:0][1:0]  tgt, resp;
  int               nchk = 0;
  int               nerr = 0;

  // instance a: IN=2 OUT=1 SETTLE=1; b: IN=2 OUT=1 SETTLE=3; c: IN=3 OUT=2 SETTLE=1
  logic [3:0][0:0] tgt_a;
  logic [0:0]      co_a, co_b;
  logic [1:0]      co_c;
  logic [1:0]      inp_a, inp_b;
  logic [2:0]      inp_c;
  logic            busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic            perf_a, perf_b, perf_c;
  logic [2:0]      fit_a, fit_b;
  logic [4:0]      fit_c;
  logic [3:0]      err_a, err_b;
  logic [7:0]      err_c;
  logic            st_a, st_b, st_c;

  assign st_a = start && (sel == 0);
  assign st_b = start && (sel == 1);
  assign st_c = start && (sel == 2);

  always_comb begin
    for (int v = 0; v < 4; v++) tgt_a[v] = tgt[v][0];
    co_a = resp[inp_a][0];
    co_b = resp[inp_b][0];
    co_c = resp[inp_c];
  end

  fitness_eval #(.IN(2), .OUT(1), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(st_a), .target(tgt_a), .circ_out(co_a),
    .circ_inp(inp_a), .busy(busy_a), .done(done_a), .fitness(fit_a),
    .perfect(perf_a), .err_map(err_a));

  fitness_eval #(.IN(2), .OUT(1), .SETTLE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(st_b), .target(tgt_a), .circ_out(co_b),
    .circ_inp(inp_b), .busy(busy_b), .done(done_b), .fitness(fit_b),
    .perfect(perf_b), .err_map(err_b));

  fitness_eval #(.IN(3), .OUT(2), .SETTLE(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(st_c), .target(tgt), .circ_out(co_c),
    .circ_inp(inp_c), .busy(busy_c), .done(done_c), .fitness(fit_c),
    .perfect(perf_c), .err_map(err_c));

  int o_inp, o_busy, o_done, o_fit, o_perf, o_err;

  always_comb begin
    case (sel)
      1: begin
        o_inp = int'(inp_b); o_busy = int'(busy_b); o_done = int'(done_b);
        o_fit = int'(fit_b); o_perf = int'(perf_b); o_err = int'(err_b);
      end
      2: begin
        o_inp = int'(inp_c); o_busy = int'(busy_c); o_done = int'(done_c);
        o_fit = int'(fit_c); o_perf = int'(perf_c); o_err = int'(err_c);
      end
      default: begin
        o_inp = int'(inp_a); o_busy = int'(busy_a); o_done = int'(done_a);
        o_fit = int'(fit_a); o_perf = int'(perf_a); o_err = int'(err_a);
      end
    endcase
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", name, act, exp, sel, $time);
    end
  endtask

  function automatic logic [7:0][1:0] w4(input logic [3:0] x);
    logic [7:0][1:0] r;
    r = '0;
    for (int v = 0; v < 4; v++) r[v] = {1'b0, x[v]};
    return r;
  endfunction

  function automatic int exp_err(input int e);
`ifdef FITNESS_ERRMAP_EN
    return e;
`else
    return 0;
`endif
  endfunction

  // Reference: count equal bits over the whole truth table of the selected geometry.
  task automatic model(input int s, output int fit, output int perf, output int err);
    int nvec, outw;
    nvec = (s == 2) ? 8 : 4;
    outw = (s == 2) ? 2 : 1;
    fit = 0; err = 0;
    for (int v = 0; v < nvec; v++) begin
      bit bad = 1'b0;
      for (int o = 0; o < outw; o++) begin
        if (resp[v][o] == tgt[v][o]) fit++;
        else bad = 1'b1;
      end
      if (bad) err |= (1 << v);
    end
    perf = (fit == nvec*outw) ? 1 : 0;
  endtask

  // Called at a negedge while idle; returns at the negedge of the IDLE cycle after done.
  task automatic run_eval(input bit repulse);
    int nvec, settle, n;
    nvec   = (sel == 2) ? 8 : 4;
    settle = (sel == 1) ? 3 : 1;
    n      = nvec * settle;
    start  = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      chk("done", o_done, (c == n + 1) ? 1 : 0);
      chk("busy", o_busy, (c <= n + 1) ? 1 : 0);
      chk("circ_inp", o_inp, (c <= n) ? (c - 1) / settle : 0);
      if (c == 1) chk("fit_cleared", o_fit, 0);
      start = repulse && (c == 2 || c == 4);
    end
    start = 1'b0;
  endtask

  typedef struct {
    int              s;
    logic [7:0][1:0] t;
    logic [7:0][1:0] r;
    bit              rep;
    bit              twice;
    int              efit;
    int              eperf;
    int              eerr;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int mf, mp, me;
    rst_n = 1'b0; start = 1'b0; sel = 0; tgt = '0; resp = '0;

    tbl[0] = '{0, w4(4'b1111), w4(4'b1111), 1'b0, 1'b0, 4, 1, 0};
    tbl[1] = '{0, w4(4'b1000), w4(4'b0110), 1'b0, 1'b0, 1, 0, 'b1110};
    tbl[2] = '{0, w4(4'b1111), w4(4'b1111), 1'b1, 1'b0, 4, 1, 0};
    tbl[3] = '{1, w4(4'b1111), w4(4'b0101), 1'b0, 1'b0, 2, 0, 'b1010};
    tbl[4] = '{2, 16'h9C3A, 16'h9C3A, 1'b0, 1'b1, 16, 1, 0};

    repeat (2) @(negedge clk);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_inp", o_inp, 0);
    chk("rst_fit", o_fit, 0);
    chk("rst_err", o_err, 0);
    chk("rst_fit_c", int'(fit_c), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      sel = tbl[i].s; tgt = tbl[i].t; resp = tbl[i].r;
      for (int k = 0; k < (tbl[i].twice ? 2 : 1); k++) begin
        run_eval(tbl[i].rep);
        chk("tbl_fit", o_fit, tbl[i].efit);
        chk("tbl_perf", o_perf, tbl[i].eperf);
        chk("tbl_err", o_err, exp_err(tbl[i].eerr));
      end
      @(negedge clk);
      chk("tbl_fit_hold", o_fit, tbl[i].efit);
    end

    // reset while circ_inp=2 aborts the run without a done pulse
    sel = 0; tgt = w4(4'b1111); resp = w4(4'b1111);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst_inp", o_inp, 2);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_busy", o_busy, 0);
    chk("abort_inp", o_inp, 0);
    chk("abort_fit", o_fit, 0);
    chk("abort_done", o_done, 0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("abort_no_done", o_done, 0);
    end

    for (int k = 0; k < 10; k++) begin
      sel = int'($urandom_range(0, 2));
      tgt = 16'($urandom);
      resp = ($urandom_range(0, 3) == 0) ? tgt : 16'($urandom);
      model(sel, mf, mp, me);
      run_eval(1'b0);
      chk("rnd_fit", o_fit, mf);
      chk("rnd_perf", o_perf, mp);
      chk("rnd_err", o_err, exp_err(me));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule

`default_nettype wire
